// File: rtl/ds1302_burst_engine_if.sv
// Command-controller side of the DS1302 burst engine.
// Transfer setup, per-byte write/read streaming and status.
interface ds1302_burst_engine_if;
  logic       Start_Sig;
  logic       Rd_nWr;
  logic       RAM_nClk;
  logic       Burst_En;
  logic [4:0] Cmd_Addr;
  logic [4:0] Burst_Len;
  logic [7:0] Wr_Data;
  logic       Wr_Req;
  logic [7:0] Rd_Data;
  logic       Rd_Valid;
  logic       Busy;
  logic       Done_Sig;

  modport master (
    output Start_Sig, Rd_nWr, RAM_nClk, Burst_En,
    output Cmd_Addr, Burst_Len, Wr_Data,
    input  Wr_Req, Rd_Data, Rd_Valid, Busy, Done_Sig
  );

  modport slave (
    input  Start_Sig, Rd_nWr, RAM_nClk, Burst_En,
    input  Cmd_Addr, Burst_Len, Wr_Data,
    output Wr_Req, Rd_Data, Rd_Valid, Busy, Done_Sig
  );
endinterface

// File: rtl/ds1302_burst_engine.sv
// DS1302 3-wire access engine: single-byte and burst transfers
// with programmable SCLK rate and CE setup/hold.
module ds1302_burst_engine #(
  parameter int CLK_DIV   = 25,
  parameter int CE_SETUP  = 50,
  parameter int CE_HOLD   = 50,
  parameter int MAX_BURST = 31
) (
  input  logic CLK,
  input  logic RSTn,
  ds1302_burst_engine_if.slave ctl,
  output logic RST,
  output logic SCLK,
  inout  wire  SIO
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CE_MAX = (CE_SETUP > CE_HOLD) ? CE_SETUP : CE_HOLD;
  localparam int TW = (CE_MAX > 1) ? $clog2(CE_MAX) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SET_LAST = TW'(CE_SETUP - 1);
  localparam logic [TW-1:0] HLD_LAST = TW'(CE_HOLD - 1);
  localparam logic [4:0] CLK_LAST = 5'd7;
  localparam logic [4:0] RAM_LAST = 5'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_DATA,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state, nstate;

  logic [DW-1:0] div_cnt;
  logic          half;
  logic [2:0]    bit_cnt;
  logic [4:0]    byte_cnt;
  logic [TW-1:0] tmr;
  logic [7:0]    sh;
  logic [7:0]    wbuf;
  logic [6:0]    rsh;
  logic          rd_r;
  logic [4:0]    last_byte;
  logic [7:0]    rd_data;
  logic          rd_valid;

  logic       sio_oe;
  logic       busy;
  logic       done;
  logic       wr_req;
  logic       div_end;
  logic       cell_end;
  logic       samp;
  logic       byte_end;
  logic       xfer_end;
  logic       start;
  logic       shifting;
  logic [4:0] cap_last;
  logic [4:0] last_in;
  logic [4:0] addr_in;
  logic [7:0] cmd_in;

  assign start    = (state == S_IDLE) & ctl.Start_Sig;
  assign shifting = (state == S_CMD) | (state == S_DATA);
  assign div_end  = (div_cnt == DIV_LAST);
  assign cell_end = half & div_end;
  assign samp     = ~half & div_end;
  assign byte_end = cell_end & (bit_cnt == 3'd7);
  assign xfer_end = byte_end & (byte_cnt == last_byte);

  assign cap_last = ctl.RAM_nClk ? RAM_LAST : CLK_LAST;
  assign last_in  = ~ctl.Burst_En ? 5'd0 :
                    (ctl.Burst_Len > cap_last) ? cap_last :
                    ctl.Burst_Len;
  assign addr_in  = ctl.Burst_En ? 5'h1F : ctl.Cmd_Addr;
  assign cmd_in   = {1'b1, ctl.RAM_nClk, addr_in, ctl.Rd_nWr};

  assign SIO = sio_oe ? sh[0] : 1'bz;

  assign ctl.Busy     = busy;
  assign ctl.Done_Sig = done;
  assign ctl.Wr_Req   = wr_req;
  assign ctl.Rd_Data  = rd_data;
  assign ctl.Rd_Valid = rd_valid;

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= nstate;
  end

  // Next-state sequencing through the transfer phases
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (ctl.Start_Sig) nstate = S_SETUP;
      S_SETUP: if (tmr == SET_LAST) nstate = S_CMD;
      S_CMD:   if (byte_end) nstate = S_DATA;
      S_DATA:  if (xfer_end) nstate = S_HOLD;
      S_HOLD:  if (tmr == HLD_LAST) nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Pin and status outputs decoded from state and bit-cell phase
  always_comb begin
    RST    = 1'b0;
    SCLK   = 1'b0;
    sio_oe = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      S_SETUP: begin
        RST  = 1'b1;
        busy = 1'b1;
      end
      S_CMD: begin
        RST    = 1'b1;
        busy   = 1'b1;
        SCLK   = half;
        sio_oe = 1'b1;
      end
      S_DATA: begin
        RST    = 1'b1;
        busy   = 1'b1;
        SCLK   = half;
        sio_oe = ~rd_r;
      end
      S_HOLD: begin
        RST  = 1'b1;
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // First cycle of write byte k>=1: that byte has just entered the shifter
  assign wr_req = (state == S_DATA) & ~rd_r
                & (byte_cnt != 5'd0) & (bit_cnt == 3'd0)
                & ~half & (div_cnt == '0);

  // Datapath: CE timer, bit-cell counters, shifters, read capture
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      div_cnt   <= '0;
      half      <= 1'b0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 5'd0;
      tmr       <= '0;
      sh        <= 8'h00;
      wbuf      <= 8'h00;
      rsh       <= 7'h00;
      rd_r      <= 1'b0;
      last_byte <= 5'd0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;

      if (start) begin
        sh        <= cmd_in;
        wbuf      <= ctl.Wr_Data;
        rd_r      <= ctl.Rd_nWr;
        last_byte <= last_in;
      end

      if ((state == S_SETUP && tmr != SET_LAST) ||
          (state == S_HOLD && tmr != HLD_LAST))
        tmr <= tmr + TW'(1);
      else
        tmr <= '0;

      if (shifting) begin
        div_cnt <= div_end ? '0 : div_cnt + DW'(1);
        if (div_end) half <= ~half;
        if (cell_end) begin
          bit_cnt <= bit_cnt + 3'd1;
          sh      <= {1'b0, sh[7:1]};
        end
        if (byte_end && state == S_CMD) sh <= wbuf;
        if (byte_end && state == S_DATA) begin
          byte_cnt <= byte_cnt + 5'd1;
          if (!xfer_end) sh <= ctl.Wr_Data;
        end
        if (state == S_DATA && rd_r && samp) begin
          rsh <= {SIO, rsh[6:1]};
          if (bit_cnt == 3'd7) begin
            rd_data  <= {SIO, rsh};
            rd_valid <= 1'b1;
          end
        end
      end else begin
        div_cnt  <= '0;
        half     <= 1'b0;
        bit_cnt  <= 3'd0;
        byte_cnt <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_ds1302_burst_engine.sv
// Bench for ds1302_burst_engine with a DS1302 pin-level model
// and a byte-array reference of clock/RAM contents.
module tb_ds1302_burst_engine;

  localparam int CD = 2;
  localparam int SU = 2;
  localparam int HD = 2;
  localparam int MB = 31;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic RST;
  logic SCLK;
  wire  SIO;

  ds1302_burst_engine_if bus ();

  ds1302_burst_engine #(
    .CLK_DIV(CD),
    .CE_SETUP(SU),
    .CE_HOLD(HD),
    .MAX_BURST(MB)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .ctl(bus),
    .RST(RST),
    .SCLK(SCLK),
    .SIO(SIO)
  );

  always #5 CLK = ~CLK;

  // DS1302 device model
  logic       m_oe = 1'b0;
  logic       m_bit = 1'b0;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_sr = 8'h00;
  int         m_bitn = 0;
  logic [7:0] mem_clk [32] = '{default: 8'h00};
  logic [7:0] mem_ram [32] = '{default: 8'h00};

  assign SIO = m_oe ? m_bit : 1'bz;

  function automatic int m_slot(input int k);
    int b;
    b = (m_cmd[5:1] == 5'h1F) ? 0 : int'(m_cmd[5:1]);
    return (b + k) % 32;
  endfunction

  always @(posedge SCLK or negedge SCLK or negedge RST) begin
    if (!RST) begin
      m_oe   = 1'b0;
      m_bitn = 0;
    end else if (SCLK) begin
      if (m_bitn < 8) begin
        m_cmd[3'(m_bitn)] = SIO;
      end else if (!m_cmd[0]) begin
        m_sr[3'(m_bitn - 8)] = SIO;
        if ((m_bitn - 8) % 8 == 7) begin
          if (m_cmd[6]) mem_ram[m_slot((m_bitn - 8) / 8)] = m_sr;
          else          mem_clk[m_slot((m_bitn - 8) / 8)] = m_sr;
        end
      end
      m_bitn++;
    end else if (m_bitn >= 8 && m_cmd[0]) begin
      if (m_cmd[6]) m_bit = mem_ram[m_slot((m_bitn - 8) / 8)][3'(m_bitn - 8)];
      else          m_bit = mem_clk[m_slot((m_bitn - 8) / 8)][3'(m_bitn - 8)];
      m_oe = 1'b1;
    end
  end

  // Reference contents and stimulus
  logic [7:0] ref_clk [32] = '{default: 8'h00};
  logic [7:0] ref_ram [32] = '{default: 8'h00};
  logic [7:0] wbytes [32];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit rd, input bit ram, input bit bst,
                      input logic [4:0] addr, input logic [4:0] len,
                      input int inj_cyc, input bit inj_done,
                      input int abort_cyc);
    int n, cap, lat, cyc, wreq, rval, widx, base, slot;
    logic [7:0] cmd, exp_b;
    bit fin;
    cap  = ram ? MB : 8;
    n    = bst ? ((int'(len) + 1 < cap) ? int'(len) + 1 : cap) : 1;
    lat  = SU + 16 * CD * (1 + n) + HD + 1;
    cmd  = {1'b1, ram, (bst ? 5'h1F : addr), rd};
    base = bst ? 0 : int'(addr);
    wreq = 0;
    rval = 0;
    fin  = 1'b0;
    @(negedge CLK);
    bus.Start_Sig = 1'b1;
    bus.Rd_nWr    = rd;
    bus.RAM_nClk  = ram;
    bus.Burst_En  = bst;
    bus.Cmd_Addr  = addr;
    bus.Burst_Len = len;
    bus.Wr_Data   = wbytes[0];
    @(negedge CLK);
    bus.Start_Sig = 1'b0;
    bus.Rd_nWr    = ~rd;
    bus.RAM_nClk  = ~ram;
    bus.Burst_En  = ~bst;
    bus.Cmd_Addr  = ~addr;
    bus.Burst_Len = ~len;
    bus.Wr_Data   = wbytes[1];
    widx = 1;
    cyc  = 1;
    chk("busy_after_start", 32'(bus.Busy), 32'd1);
    while (!fin) begin
      bus.Start_Sig = (cyc == inj_cyc);
      if (cyc == abort_cyc) begin
        RSTn = 1'b0;
        #1;
        chk("abort_rst", 32'(RST), 32'd0);
        chk("abort_sclk", 32'(SCLK), 32'd0);
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_sio_rel", 32'(dut.sio_oe), 32'd0);
        @(negedge CLK);
        chk("abort_no_done", 32'(bus.Done_Sig), 32'd0);
        RSTn = 1'b1;
        return;
      end
      if (cyc == SU + 16 * CD)
        chk("sio_drv_cmd_end", 32'(dut.sio_oe), 32'd1);
      if (cyc == SU + 16 * CD + 1)
        chk("sio_drv_data", 32'(dut.sio_oe), 32'(!rd));
      if (bus.Wr_Req) begin
        wreq++;
        widx++;
        bus.Wr_Data = wbytes[widx % 32];
      end
      if (bus.Rd_Valid) begin
        slot  = (base + rval) % 32;
        exp_b = ram ? ref_ram[slot] : ref_clk[slot];
        chk("rd_data", 32'(bus.Rd_Data), 32'(exp_b));
        rval++;
      end
      if (bus.Done_Sig) begin
        fin = 1'b1;
        chk("done_latency", 32'(cyc), 32'(lat));
        chk("busy_at_done", 32'(bus.Busy), 32'd0);
      end else if (cyc >= lat + 8) begin
        fin = 1'b1;
        chk("done_timeout", 32'(cyc), 32'(lat));
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end
    bus.Start_Sig = 1'b0;
    chk("cmd_byte", 32'(m_cmd), 32'(cmd));
    chk("wr_req_count", 32'(wreq), 32'(rd ? 0 : n - 1));
    chk("rd_valid_count", 32'(rval), 32'(rd ? n : 0));
    if (inj_done) begin
      bus.Start_Sig = 1'b1;
      @(negedge CLK);
      bus.Start_Sig = 1'b0;
      chk("start_on_done_busy", 32'(bus.Busy), 32'd0);
      @(negedge CLK);
      chk("start_on_done_busy2", 32'(bus.Busy), 32'd0);
      chk("start_on_done_done", 32'(bus.Done_Sig), 32'd0);
    end
    if (!rd) begin
      for (int i = 0; i < n; i++) begin
        slot = (base + i) % 32;
        if (ram) begin
          chk("dev_ram_wr", 32'(mem_ram[slot]), 32'(wbytes[i]));
          ref_ram[slot] = wbytes[i];
        end else begin
          chk("dev_clk_wr", 32'(mem_clk[slot]), 32'(wbytes[i]));
          ref_clk[slot] = wbytes[i];
        end
      end
    end
  endtask

  initial begin
    bit rd, ram, bst;
    logic [4:0] addr, len;
    bus.Start_Sig = 1'b0;
    bus.Rd_nWr    = 1'b0;
    bus.RAM_nClk  = 1'b0;
    bus.Burst_En  = 1'b0;
    bus.Cmd_Addr  = 5'd0;
    bus.Burst_Len = 5'd0;
    bus.Wr_Data   = 8'h00;
    for (int i = 0; i < 32; i++) wbytes[i] = 8'h00;
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_RST", 32'(RST), 32'd0);
    chk("rst_SCLK", 32'(SCLK), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done_Sig), 32'd0);
    chk("rst_wr_req", 32'(bus.Wr_Req), 32'd0);
    chk("rst_rd_valid", 32'(bus.Rd_Valid), 32'd0);
    chk("rst_rd_data", 32'(bus.Rd_Data), 32'd0);
    chk("rst_sio_rel", 32'(dut.sio_oe), 32'd0);
    RSTn = 1'b1;

    // single write 0x59 to clock reg 0
    wbytes[0] = 8'h59;
    xfer(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, -1, 1'b0, -1);
    // single write 0x23 to clock reg 2, then read it back
    wbytes[0] = 8'h23;
    xfer(1'b0, 1'b0, 1'b0, 5'd2, 5'd0, -1, 1'b0, -1);
    xfer(1'b1, 1'b0, 1'b0, 5'd2, 5'd0, -1, 1'b0, -1);
    chk("single_read_byte", 32'(bus.Rd_Data), 32'h23);

    // clock burst: fill, then read with oversized length
    for (int i = 0; i < 32; i++) wbytes[i] = 8'($urandom);
    xfer(1'b0, 1'b0, 1'b1, 5'd0, 5'd7, -1, 1'b0, -1);
    xfer(1'b1, 1'b0, 1'b1, 5'd4, 5'd31, -1, 1'b0, -1);

    // RAM burst write of four bytes
    for (int i = 0; i < 4; i++) wbytes[i] = 8'hA1 + 8'(i);
    xfer(1'b0, 1'b1, 1'b1, 5'd0, 5'd3, -1, 1'b0, -1);
    chk("ram_burst_cmd", 32'(m_cmd), 32'hFE);

    // Start pulses mid-transfer and on the Done cycle are ignored
    wbytes[0] = 8'h3C;
    xfer(1'b0, 1'b1, 1'b0, 5'd10, 5'd0, 20, 1'b1, -1);

    // async reset during the data phase, then a fresh read
    xfer(1'b0, 1'b1, 1'b1, 5'd0, 5'd3, -1, 1'b0, SU + 16 * CD + 40);
    xfer(1'b1, 1'b1, 1'b0, 5'd1, 5'd0, -1, 1'b0, -1);
    chk("read_after_abort", 32'(bus.Rd_Data), 32'hA2);

    // randomized transfers against the reference contents
    for (int t = 0; t < 10; t++) begin
      rd   = 1'($urandom);
      ram  = 1'($urandom);
      bst  = 1'($urandom);
      addr = 5'($urandom_range(0, 30));
      len  = 5'($urandom);
      for (int i = 0; i < 32; i++) wbytes[i] = 8'($urandom);
      xfer(rd, ram, bst, addr, len, -1, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
